// File: rtl/int2float_pkg.sv
// int2float_pkg: shared state enum, fp16 field widths and the packed fp16 result type.
package int2float_pkg;
    localparam int INT_W   = 16;
    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int FP_BIAS = 15;
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(2 * FP_BIAS);

    typedef enum logic [3:0] {
        IDLE, RD_HI, RD_LO, ABS, NORM, ROUND, WR_HI, WR_LO, DONE
    } i2f_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;
endpackage

// File: rtl/int2float_engine_fp_round.sv
// fp_round: mantissa extraction from a normalized magnitude; rounds to nearest even
// when INT2FLOAT_ROUND_EN is defined, otherwise truncates.
module fp_round
    import int2float_pkg::*;
(
    input  logic [INT_W-1:0] i_mag,
    input  logic [EXP_W-1:0] i_exp,
    output logic [MAN_W-1:0] o_man,
    output logic [EXP_W-1:0] o_exp
);
    logic           w_inc;
    logic           w_unused;
    logic [MAN_W:0] w_sum;
`ifdef INT2FLOAT_ROUND_EN
    assign w_inc    = i_mag[4] & ((|i_mag[3:0]) | i_mag[5]);
    assign w_unused = i_mag[INT_W-1];
`else
    assign w_inc    = 1'b0;
    assign w_unused = ^{i_mag[INT_W-1], i_mag[4:0]};
`endif
    // A carry out of the mantissa renormalizes by bumping the exponent; the field wraps to 0.
    assign w_sum = {1'b0, i_mag[14:5]} + {{MAN_W{1'b0}}, w_inc};
    assign o_man = w_sum[MAN_W-1:0];
    assign o_exp = i_exp + {{(EXP_W-1){1'b0}}, w_sum[MAN_W]};
endmodule

// File: rtl/int2float_engine.sv
// int2float_engine: reads a 16-bit integer from data_mem, normalizes it serially and writes back fp16.
// Rounding mode selected by INT2FLOAT_ROUND_EN (see fp_round).
module int2float_engine
    import int2float_pkg::*;
#(
    parameter logic [7:0] SRC_ADDR = 8'd0,
    parameter logic [7:0] DST_ADDR = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_addr,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done
);
    i2f_state_t       r_state;
    logic [7:0]       r_int_hi;
    logic [7:0]       r_int_lo;
    logic             r_sign;
    logic [INT_W-1:0] r_mag;
    logic [EXP_W-1:0] r_exp;
    fp16_t            r_result;
    logic [INT_W-1:0] w_int;
    logic [INT_W-1:0] w_abs;
    logic [MAN_W-1:0] w_man;
    logic [EXP_W-1:0] w_exp;

    assign w_int = {r_int_hi, r_int_lo};
    // 0x8000 negates to itself, which read as unsigned is the required 32768.
    assign w_abs = w_int[INT_W-1] ? -w_int : w_int;

    fp_round u_round (
        .i_mag (r_mag),
        .i_exp (r_exp),
        .o_man (w_man),
        .o_exp (w_exp)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_int_hi <= '0;
            r_int_lo <= '0;
            r_sign   <= 1'b0;
            r_mag    <= '0;
            r_exp    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: r_state <= start ? RD_HI : r_state;
                RD_HI: begin
                    r_int_hi <= mem_rdata;
                    r_state  <= RD_LO;
                end
                RD_LO: begin
                    r_int_lo <= mem_rdata;
                    r_state  <= ABS;
                end
                ABS: begin
                    r_sign   <= w_int[INT_W-1];
                    r_mag    <= w_abs;
                    r_exp    <= EXP_TOP;
                    r_result <= '0;
                    r_state  <= (w_abs == '0) ? WR_HI : NORM;
                end
                NORM: begin
                    if (r_mag[INT_W-1]) begin
                        r_state <= ROUND;
                    end else begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 1'b1;
                    end
                end
                ROUND: begin
                    r_result <= '{sign: r_sign, exp: w_exp, man: w_man};
                    r_state  <= WR_HI;
                end
                WR_HI:   r_state <= WR_LO;
                WR_LO:   r_state <= DONE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_read  = (r_state == RD_HI) || (r_state == RD_LO);
        mem_write = (r_state == WR_HI) || (r_state == WR_LO);
        mem_addr  = (r_state == RD_HI) ? SRC_ADDR :
                    (r_state == RD_LO) ? SRC_ADDR + 8'd1 :
                    (r_state == WR_HI) ? DST_ADDR :
                    (r_state == WR_LO) ? DST_ADDR + 8'd1 : 8'd0;
        mem_wdata = (r_state == WR_HI) ? r_result[15:8] :
                    (r_state == WR_LO) ? r_result[7:0] : 8'd0;
        busy      = (r_state != IDLE) && (r_state != DONE);
        done      = (r_state == DONE);
    end
endmodule

// File: tb/tb_int2float_engine.sv
// tb_int2float_engine: randomized scoreboard bench; expected fp16 values and done timing come from
// an arithmetic reference model, a negedge monitor compares memory contents when done rises.
module tb_int2float_engine;
    localparam logic [7:0] SRC = 8'd0;
    localparam logic [7:0] DST = 8'd2;

    typedef struct {
        logic [15:0] res;
        int          cyc;
    } exp_t;

    logic       clk = 0;
    logic       reset;
    logic       start;
    logic [7:0] mem_rdata, mem_addr, mem_wdata;
    logic       mem_read, mem_write, busy, done;
    logic [7:0] mem [256];
    logic [15:0] src_val;
    exp_t       q [$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         wr_cnt = 0;
    logic       prev_done = 0;

    int2float_engine #(.SRC_ADDR(SRC), .DST_ADDR(DST)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr == SRC) ? src_val[15:8] :
                       (mem_addr == SRC + 8'd1) ? src_val[7:0] : mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    function automatic logic [15:0] ref_fp(input logic [15:0] x);
        int v, m, e, q2;
        logic s;
        v = $signed(x);
        s = v < 0;
        m = s ? -v : v;
        if (m == 0) return 16'h0000;
        e = $clog2(m + 1) - 1;
        if (e <= 10) q2 = m << (10 - e);
        else begin
            q2 = m >> (e - 10);
`ifdef INT2FLOAT_ROUND_EN
            begin
                int r, h;
                r = m - (q2 << (e - 10));
                h = 1 << (e - 11);
                if (r > h || (r == h && q2 % 2 == 1)) q2++;
            end
`endif
            if (q2 == 2048) begin
                q2 = 1024;
                e++;
            end
        end
        return {s, 5'(e + 15), 10'(q2 - 1024)};
    endfunction

    function automatic int ref_lat(input logic [15:0] x);
        int v, m;
        v = $signed(x);
        m = v < 0 ? -v : v;
        return (m == 0) ? 5 : 7 + 15 - ($clog2(m + 1) - 1);
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            wr_cnt    = 0;
            prev_done = 0;
        end else begin
            if (mem_write) begin
                wr_cnt++;
                checks++;
                if (mem_addr != DST && mem_addr != DST + 8'd1) begin
                    errors++;
                    $display("FAIL wr_addr: got %h expected %h or %h", mem_addr, DST, DST + 8'd1);
                end
            end
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done: done rose at cycle %0d with nothing outstanding", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checks += 3;
                    if ({mem[DST], mem[DST + 8'd1]} !== e.res) begin
                        errors++;
                        $display("FAIL result: got %h expected %h", {mem[DST], mem[DST + 8'd1]}, e.res);
                    end
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL latency: done at cycle %0d expected %0d", cyc, e.cyc);
                    end
                    if (wr_cnt != 2) begin
                        errors++;
                        $display("FAIL write_count: got %0d expected 2", wr_cnt);
                    end
                end
                wr_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({done, busy, mem_read, mem_write, mem_addr, mem_wdata} !== 20'h0) begin
            errors++;
            $display("FAIL %s: got done=%b busy=%b rd=%b wr=%b addr=%h wdata=%h expected all 0",
                     name, done, busy, mem_read, mem_write, mem_addr, mem_wdata);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: done=%b expected 1 within 40 cycles", done);
        end
    endtask

    task automatic launch(input logic [15:0] x);
        exp_t e;
        src_val = x;
        e.res = ref_fp(x);
        e.cyc = cyc + ref_lat(x) + 1;
        q.push_back(e);
        start = 1;
    endtask

    task automatic run(input logic [15:0] x, input logic hold);
        launch(x);
        @(negedge clk);
        start = hold;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL launch_flags: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        wait_done();
    endtask

    initial begin
        logic [15:0] dir [6];
        dir = '{16'h0001, 16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0801};
        reset = 0;
        start = 0;
        src_val = 0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        reset = 1;
        @(negedge clk);
        foreach (dir[i]) run(dir[i], 1'b0);
        for (int i = 0; i < 40; i++) run(16'($urandom), 1'($urandom_range(0, 1)));
        start = 0;
        @(negedge clk);
        // Abort a conversion while it is normalizing.
        launch(16'h0001);
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        reset = 0;
        #1 check_idle_outputs("reset_async");
        q.delete();
        @(negedge clk);
        check_idle_outputs("reset_held");
        reset = 1;
        @(negedge clk);
        launch(16'h0001);
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done();
        repeat (4) @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: got done=%b busy=%b expected done=1 busy=0", done, busy);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL outstanding: got %0d expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
